// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS-subset controller:
// opcodes, funcs, ALU codes, ALU-B mux codes and FSM states.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC_R  = 4'd3;
    localparam logic [3:0] S_WB_R    = 4'd4;
    localparam logic [3:0] S_MEMADDR = 4'd5;
    localparam logic [3:0] S_MEMRD   = 4'd6;
    localparam logic [3:0] S_MEMWB   = 4'd7;
    localparam logic [3:0] S_MEMWR   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_LUI_EX  = 4'd10;
    localparam logic [3:0] S_LUI_WB  = 4'd11;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       pcsrc;
        logic       iord;
        logic       memr;
        logic       memw;
        logic       irwrite;
        logic       regdst;
        logic       regw;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle: IR fields and mem_ready in,
// datapath control strobes and debug state out.
interface mc_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcsrc;
    logic       iord;
    logic       memr;
    logic       memw;
    logic       irwrite;
    logic       regdst;
    logic       regw;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  op, func, mem_ready,
        output pcwrite, pcwritecond, pcsrc, iord, memr, memw, irwrite,
        output regdst, regw, memtoreg, alusrca, alusrcb, aluop,
        output instr_done, illegal, bus_err, state
    );

    modport slave (
        output op, func, mem_ready,
        input  pcwrite, pcwritecond, pcsrc, iord, memr, memw, irwrite,
        input  regdst, regw, memtoreg, alusrca, alusrcb, aluop,
        input  instr_done, illegal, bus_err, state
    );
endinterface

// File: rtl/mc_alu_decode.sv
// R-type func to ALU operation map, plus a flag for supported funcs.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] aluop,
    output logic       rtype_ok
);

    always_comb begin
        aluop    = ALU_ADD;
        rtype_ok = 1'b1;
        unique case (1'b1)
            (func == FN_ADD): aluop = ALU_ADD;
            (func == FN_SUB): aluop = ALU_SUB;
            (func == FN_AND): aluop = ALU_AND;
            (func == FN_OR):  aluop = ALU_OR;
            (func == FN_XOR): aluop = ALU_XOR;
            default:          rtype_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle controller FSM with memory wait counter and bus timeout.
// Outputs decode from state, with mem_ready gating in memory states.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input logic clk,
    input logic rst_n,
    mc_if.master bus
);

    localparam logic [3:0] WMAX = 4'(WAIT_MAX);

    logic [3:0] st;
    logic [3:0] nxt;
    logic [3:0] cnt;
    logic [2:0] fn_alu;
    logic       rt_ok;
    logic       waiting;
    ctrl_t      c;

    mc_alu_decode u_dec (
        .func    (bus.func),
        .aluop   (fn_alu),
        .rtype_ok(rt_ok)
    );

    assign waiting = (st == S_FETCH || st == S_MEMRD || st == S_MEMWR)
                     && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= S_RST;
            cnt <= 4'd0;
        end else begin
            st <= nxt;
            if (nxt != st)
                cnt <= 4'd0;
            else if (waiting)
                cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        c   = '0;
        nxt = st;
        unique case (st)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                c.memr    = 1'b1;
                c.alusrcb = SRCB_4;
                c.aluop   = ALU_ADD;
                if (bus.mem_ready) begin
                    c.irwrite = 1'b1;
                    c.pcwrite = 1'b1;
                    nxt       = S_DECODE;
                end else if (cnt == WMAX) begin
                    c.bus_err = 1'b1;
                    nxt       = S_RST;
                end
            end
            S_DECODE: begin
                c.alusrcb = SRCB_BR;
                c.aluop   = ALU_ADD;
                unique case (1'b1)
                    (bus.op == OP_RTYPE && rt_ok):     nxt = S_EXEC_R;
                    (bus.op == OP_LW || bus.op == OP_SW): nxt = S_MEMADDR;
                    (bus.op == OP_BEQ):                 nxt = S_BRANCH;
                    (bus.op == OP_LUI):                 nxt = S_LUI_EX;
                    default: begin
                        c.illegal = 1'b1;
                        nxt       = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = fn_alu;
                nxt       = S_WB_R;
            end
            S_WB_R: begin
                c.regdst     = 1'b1;
                c.regw       = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEMADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALU_ADD;
                nxt       = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c.memr = 1'b1;
                c.iord = 1'b1;
                if (bus.mem_ready) begin
                    nxt = S_MEMWB;
                end else if (cnt == WMAX) begin
                    c.bus_err = 1'b1;
                    nxt       = S_RST;
                end
            end
            S_MEMWB: begin
                c.regw       = 1'b1;
                c.memtoreg   = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            S_MEMWR: begin
                c.memw = 1'b1;
                c.iord = 1'b1;
                if (bus.mem_ready) begin
                    c.instr_done = 1'b1;
                    nxt          = S_FETCH;
                end else if (cnt == WMAX) begin
                    c.bus_err = 1'b1;
                    nxt       = S_RST;
                end
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_B;
                c.aluop       = ALU_SUB;
                c.pcwritecond = 1'b1;
                c.pcsrc       = 1'b1;
                c.instr_done  = 1'b1;
                nxt           = S_FETCH;
            end
            S_LUI_EX: begin
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALU_LUI;
                nxt       = S_LUI_WB;
            end
            S_LUI_WB: begin
                c.regw       = 1'b1;
                c.instr_done = 1'b1;
                nxt          = S_FETCH;
            end
            default: nxt = S_RST;
        endcase
    end

    assign bus.pcwrite     = c.pcwrite;
    assign bus.pcwritecond = c.pcwritecond;
    assign bus.pcsrc       = c.pcsrc;
    assign bus.iord        = c.iord;
    assign bus.memr        = c.memr;
    assign bus.memw        = c.memw;
    assign bus.irwrite     = c.irwrite;
    assign bus.regdst      = c.regdst;
    assign bus.regw        = c.regw;
    assign bus.memtoreg    = c.memtoreg;
    assign bus.alusrca     = c.alusrca;
    assign bus.alusrcb     = c.alusrcb;
    assign bus.aluop       = c.aluop;
    assign bus.instr_done  = c.instr_done;
    assign bus.illegal     = c.illegal;
    assign bus.bus_err     = c.bus_err;
    assign bus.state       = st;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction expected cycle traces built from
// the instruction rules, compared every cycle against state and controls.
module tb_mc_control;
    import mc_pkg::*;

    localparam int WM = 15;

    typedef struct {
        logic [3:0] st;
        bit         rdy;
        bit         berr;
        bit         ill;
        logic [2:0] alu;
        logic [5:0] op;
        logic [5:0] func;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    ent_t q[$];

    mc_if bus ();

    mc_control #(.WAIT_MAX(WM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] observed();
        return {bus.pcwrite, bus.pcwritecond, bus.pcsrc, bus.iord,
                bus.memr, bus.memw, bus.irwrite, bus.regdst, bus.regw,
                bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop,
                bus.instr_done, bus.illegal, bus.bus_err};
    endfunction

    function automatic logic [18:0] expected(ent_t e);
        logic pw, pwc, ps, io, mr, mw, irw, rd, rw, m2r, sa, dn, il, be;
        logic [1:0] sb;
        logic [2:0] ao;
        {pw, pwc, ps, io, mr, mw, irw, rd, rw, m2r, sa, dn, il, be} = '0;
        sb = 2'b00;
        ao = 3'b000;
        case (e.st)
            S_FETCH: begin
                mr = 1; sb = 2'b01; irw = e.rdy; pw = e.rdy; be = e.berr;
            end
            S_DECODE:  begin sb = 2'b11; il = e.ill; end
            S_EXEC_R:  begin sa = 1; ao = e.alu; end
            S_WB_R:    begin rd = 1; rw = 1; dn = 1; end
            S_MEMADDR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:   begin mr = 1; io = 1; be = e.berr; end
            S_MEMWB:   begin rw = 1; m2r = 1; dn = 1; end
            S_MEMWR:   begin mw = 1; io = 1; dn = e.rdy; be = e.berr; end
            S_BRANCH:  begin sa = 1; ao = 3'b001; pwc = 1; ps = 1; dn = 1; end
            S_LUI_EX:  begin sb = 2'b10; ao = 3'b101; end
            S_LUI_WB:  begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pw, pwc, ps, io, mr, mw, irw, rd, rw, m2r, sa, sb, ao, dn, il, be};
    endfunction

    function automatic logic [3:0] r_alu(logic [5:0] f);
        case (f)
            6'b100000: return 4'b0000;
            6'b100010: return 4'b0001;
            6'b100100: return 4'b0010;
            6'b100101: return 4'b0011;
            6'b100110: return 4'b0100;
            default:   return 4'b1000;
        endcase
    endfunction

    task automatic check(string tag, logic [18:0] got, logic [18:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(logic [3:0] st, bit rdy, bit berr, bit ill,
                        logic [2:0] alu, logic [5:0] op, logic [5:0] fn);
        ent_t e;
        e.st = st; e.rdy = rdy; e.berr = berr; e.ill = ill;
        e.alu = alu; e.op = op; e.func = fn;
        q.push_back(e);
    endtask

    task automatic add_wait(logic [3:0] st, int n, bit to,
                            logic [5:0] op, logic [5:0] fn);
        if (to) begin
            for (int i = 0; i <= WM; i++)
                push(st, 0, i == WM, 0, 3'b000, op, fn);
            push(S_RST, 0, 0, 0, 3'b000, op, fn);
        end else begin
            for (int i = 0; i < n; i++)
                push(st, 0, 0, 0, 3'b000, op, fn);
            push(st, 1, 0, 0, 3'b000, op, fn);
        end
    endtask

    task automatic build(logic [5:0] op, logic [5:0] fn, int wf, int wm,
                         bit tof, bit tom);
        logic [3:0] ra;
        ra = r_alu(fn);
        add_wait(S_FETCH, wf, tof, op, fn);
        if (!tof) begin
            if (op == 6'b000000 && !ra[3]) begin
                push(S_DECODE, 0, 0, 0, 3'b000, op, fn);
                push(S_EXEC_R, 0, 0, 0, ra[2:0], op, fn);
                push(S_WB_R, 0, 0, 0, 3'b000, op, fn);
            end else if (op == 6'b100011 || op == 6'b101011) begin
                push(S_DECODE, 0, 0, 0, 3'b000, op, fn);
                push(S_MEMADDR, 0, 0, 0, 3'b000, op, fn);
                if (op == 6'b100011) begin
                    add_wait(S_MEMRD, wm, tom, op, fn);
                    if (!tom) push(S_MEMWB, 0, 0, 0, 3'b000, op, fn);
                end else begin
                    add_wait(S_MEMWR, wm, tom, op, fn);
                end
            end else if (op == 6'b000100) begin
                push(S_DECODE, 0, 0, 0, 3'b000, op, fn);
                push(S_BRANCH, 0, 0, 0, 3'b000, op, fn);
            end else if (op == 6'b001111) begin
                push(S_DECODE, 0, 0, 0, 3'b000, op, fn);
                push(S_LUI_EX, 0, 0, 0, 3'b000, op, fn);
                push(S_LUI_WB, 0, 0, 0, 3'b000, op, fn);
            end else begin
                push(S_DECODE, 0, 0, 1, 3'b000, op, fn);
            end
        end
    endtask

    task automatic run(string tag, int k);
        int n;
        ent_t e;
        n = (k < q.size()) ? k : q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = q[i];
            bus.op   = e.op;
            bus.func = e.func;
            if (e.st == S_FETCH || e.st == S_MEMRD || e.st == S_MEMWR)
                bus.mem_ready = e.rdy;
            else
                bus.mem_ready = 1'($urandom);
            #1;
            check({tag, "_state"}, 19'(bus.state), 19'(e.st));
            check({tag, "_ctrl"}, observed(), expected(e));
        end
        q.delete();
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        logic [5:0] fn;
        int wf, wm;
        bit tof, tom;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000000};
        bus.op = '0;
        bus.func = '0;
        bus.mem_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_hold_state", 19'(bus.state), 19'(S_RST));
            check("rst_hold_ctrl", observed(), 19'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        push(S_RST, 1, 0, 0, 3'b000, 6'd0, 6'd0);
        build(6'b000000, 6'b100010, 0, 0, 0, 0);
        build(6'b100011, 6'b000000, 0, 3, 0, 0);
        build(6'b101011, 6'b000000, 1, 2, 0, 0);
        build(6'b000100, 6'b000000, 0, 0, 0, 0);
        build(6'b001111, 6'b000000, 0, 0, 0, 0);
        build(6'b000000, 6'b101010, 0, 0, 0, 0);
        build(6'b111111, 6'b100000, 0, 0, 0, 0);
        build(6'b000000, 6'b100000, 0, 0, 1, 0);
        build(6'b000000, 6'b100110, WM, 0, 0, 0);
        build(6'b100011, 6'b000000, 0, WM, 0, 0);
        build(6'b100011, 6'b000000, 0, 0, 0, 1);
        build(6'b101011, 6'b000000, 2, 0, 0, 1);
        build(6'b000000, 6'b100101, 0, 0, 0, 0);
        run("directed", 100000);

        for (int t = 0; t < 60; t++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                 : 6'b100000 | 6'({$urandom_range(0, 3), 1'b0});
            if ($urandom_range(0, 4) == 0) fn = 6'b100110;
            wf  = ($urandom_range(0, 9) == 0) ? WM : $urandom_range(0, 3);
            wm  = ($urandom_range(0, 9) == 0) ? WM : $urandom_range(0, 3);
            tof = ($urandom_range(0, 15) == 0);
            tom = ($urandom_range(0, 11) == 0);
            build(op, fn, wf, wm, tof, tom);
            run("random", 100000);
        end

        build(6'b101011, 6'b000000, 0, 5, 0, 0);
        run("pre_abort", 5);
        rst_n = 1'b0;
        #1;
        check("abort_state", 19'(bus.state), 19'(S_RST));
        check("abort_ctrl", observed(), 19'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(S_RST, 1, 0, 0, 3'b000, 6'd0, 6'd0);
        build(6'b000000, 6'b100100, 1, 0, 0, 0);
        run("post_abort", 100000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle controller for the MIPS subset add/sub/and/or/xor (R-type), lw, sw, beq, lui.
- Sequences a shared-memory multicycle datapath (PC, IR, MDR, A/B, ALUOut registers, single memory port) through fetch/decode/execute/memory/writeback states.
- Handshakes with a variable-latency memory and flags illegal instructions and memory timeouts.
- Replaces the single-cycle decoder when the datapath moves to one shared memory.

Parameters:
- WAIT_MAX, 15, maximum cycles the memory port waits for mem_ready before bus error (1..15; counter is 4 bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if ALU zero
- pcsrc  out  1  0=ALU result, 1=ALUOut
- iord  out  1  0=PC address, 1=ALUOut address
- memr  out  1  memory read request
- memw  out  1  memory write request
- irwrite  out  1  IR load
- regdst  out  1  1=rd, 0=rt
- regw  out  1  register file write
- memtoreg  out  1  1=MDR, 0=ALUOut
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- aluop  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 lui (imm<<16)
- instr_done  out  1  one-cycle pulse at instruction completion
- illegal  out  1  one-cycle pulse on unsupported op/func
- bus_err  out  1  one-cycle pulse on memory timeout
- state  out  4  current state encoding (debug)

Behaviour:
- States: RST, FETCH, DECODE, EXEC_R, WB_R, MEMADDR, MEMRD, MEMWB, MEMWR, BRANCH, LUI_EX, LUI_WB.
- Reset: state=RST asynchronously, wait counter=0. In RST every output except state is 0. RST->FETCH unconditionally on the next edge.
- Unlisted outputs are 0 in every state. Outputs are decoded from state; irwrite/pcwrite in FETCH and state advance in memory states are also gated by mem_ready.
- FETCH: memr=1, iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=0. While mem_ready=0: hold and increment wait counter. When mem_ready=1: irwrite=1, pcwrite=1, next=DECODE, counter cleared.
- DECODE: alusrca=0, alusrcb=11, aluop=add (branch target into ALUOut). Next state by op:
  - op=000000 with func in {100000,100010,100100,100101,100110} -> EXEC_R
  - 100011 or 101011 -> MEMADDR
  - 000100 -> BRANCH
  - 001111 -> LUI_EX
  - else illegal=1 and next=FETCH; PC already advanced, so the instruction acts as a NOP.
- EXEC_R: alusrca=1, alusrcb=00, aluop from func (100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor). ->WB_R.
- WB_R: regdst=1, regw=1, memtoreg=0, instr_done=1. ->FETCH.
- MEMADDR: alusrca=1, alusrcb=10, aluop=add. ->MEMRD if op=100011, else MEMWR.
- MEMRD: memr=1, iord=1. Waits on mem_ready as in FETCH, then ->MEMWB.
- MEMWB: regdst=0, regw=1, memtoreg=1, instr_done=1. ->FETCH.
- MEMWR: memw=1, iord=1. Waits on mem_ready. On mem_ready=1: instr_done=1, ->FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcwritecond=1, pcsrc=1, instr_done=1. ->FETCH.
- LUI_EX: alusrcb=10, aluop=lui. ->LUI_WB.
- LUI_WB: regdst=0, regw=1, memtoreg=0, instr_done=1. ->FETCH.
- Timeout:
  - The wait counter counts only in FETCH/MEMRD/MEMWR while mem_ready=0.
  - On the cycle the counter equals WAIT_MAX with mem_ready still 0: bus_err=1, next=RST, no writes that cycle.
  - mem_ready=1 on that same cycle wins: normal completion, no bus_err.
- Counter clears on every state change.
- Reset mid-instruction: immediate abort to RST; no partial write enables persist past rst_n low.
- op/func are sampled only in DECODE and EXEC_R/MEMADDR; IR is stable outside FETCH.

Decomposition:
- Package mc_pkg: opcode constants, func constants, aluop codes, alusrcb codes, state encoding.
- Sub-module mc_alu_decode: combinational func->aluop map plus an R-type legality flag. Used in DECODE (legality) and EXEC_R (aluop).

Test Plan:
- Reset held 3 cycles then released, mem_ready=1 -> RST one cycle, FETCH with memr=1, iord=0, irwrite=1, pcwrite=1, all other writes 0 throughout reset.
- op=000000 func=100010, mem_ready=1 -> FETCH, DECODE, EXEC_R (aluop=001, alusrca=1, alusrcb=00), WB_R (regw=1, regdst=1); instr_done once; 4 cycles total.
- op=100011 with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with memr=1, iord=1, then MEMWB with memtoreg=1, regw=1; 5+3 cycles total.
- op=101011 -> MEMWR with memw=1, regw never 1. op=000100 -> BRANCH with pcwritecond=1, pcsrc=1, aluop=001. op=001111 -> LUI_EX aluop=101, alusrcb=10, then LUI_WB regw=1, regdst=0.
- op=000000 func=101010, then op=111111 -> illegal pulse in DECODE, return to FETCH, regw/memw never asserted.
- mem_ready held 0 in FETCH, WAIT_MAX=15 -> bus_err on the 16th FETCH cycle, then RST, then FETCH; repeat with mem_ready=1 on that exact cycle -> no bus_err, DECODE next.
